// File: rtl/decoder_proj_stream_if.sv
// Stream bundle between the user-project input pins and the decoder: input
// handshake, buffered output handshake and error counter access.
interface decoder_proj_stream_if #(
   parameter int IN_W     = 3,
   parameter int OUT_W    = 7,
   parameter int CHANNELS = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*IN_W-1:0]  in_code;
   logic [1:0]                in_mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS*OUT_W-1:0] out_dec;
   logic [CHANNELS-1:0]       out_err;
   logic [7:0]                err_cnt;
   logic                      err_clr;

   modport slave (
      input  in_valid, in_code, in_mode, out_ready, err_clr,
      output in_ready, out_valid, out_dec, out_err, err_cnt
   );

   modport master (
      output in_valid, in_code, in_mode, out_ready, err_clr,
      input  in_ready, out_valid, out_dec, out_err, err_cnt
   );
endinterface

// File: rtl/decoder_proj_stream.sv
// Multi-channel code decoder (one-hot / thermometer / active-low one-hot)
// with a 2-entry registered output buffer and a saturating error counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no word buffered, out_valid low, outputs zero
// ST_ONE   | head holds one word, can accept and emit
// ST_FULL  | head and tail hold words, in_ready low
module decoder_proj_stream #(
   parameter int IN_W     = 3,
   parameter int OUT_W    = 7,
   parameter int CHANNELS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decoder_proj_stream_if.slave bus
);
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

   state_t                    state_q, state_d;
   logic [CHANNELS*OUT_W-1:0] head_dec_q, head_dec_d;
   logic [CHANNELS*OUT_W-1:0] tail_dec_q, tail_dec_d;
   logic [CHANNELS-1:0]       head_err_q, head_err_d;
   logic [CHANNELS-1:0]       tail_err_q, tail_err_d;
   logic [7:0]                err_cnt_q, err_cnt_d;
   logic [CHANNELS*OUT_W-1:0] new_dec;
   logic [CHANNELS-1:0]       new_err;
   logic                      push, pop;

   always_comb begin
      logic [IN_W-1:0]  k;
      logic [OUT_W-1:0] word;
      new_dec = '0;
      new_err = '0;
      k       = '0;
      word    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         k = bus.in_code[c*IN_W +: IN_W];
         for (int b = 0; b < OUT_W; b++) begin
            case (bus.in_mode)
               2'd1:    word[b] = (b <= int'(k));
               2'd2:    word[b] = (int'(k) != b);
               default: word[b] = (int'(k) == b);
            endcase
         end
         // out-of-range codes force a flat word so thermometer mode cannot leak ones
         if (int'(k) >= OUT_W) begin
            word       = (bus.in_mode == 2'd2) ? '1 : '0;
            new_err[c] = 1'b1;
         end
         new_dec[c*OUT_W +: OUT_W] = word;
      end
   end

   assign push = bus.in_valid && (state_q != ST_FULL);
   assign pop  = (state_q != ST_EMPTY) && bus.out_ready;

   always_comb begin
      state_d    = state_q;
      head_dec_d = head_dec_q;
      head_err_d = head_err_q;
      tail_dec_d = tail_dec_q;
      tail_err_d = tail_err_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               head_dec_d = new_dec;
               head_err_d = new_err;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               head_dec_d = new_dec;
               head_err_d = new_err;
            end else if (push) begin
               tail_dec_d = new_dec;
               tail_err_d = new_err;
               state_d    = ST_FULL;
            end else if (pop) begin
               head_dec_d = '0;
               head_err_d = '0;
               state_d    = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               head_dec_d = tail_dec_q;
               head_err_d = tail_err_q;
               tail_dec_d = '0;
               tail_err_d = '0;
               state_d    = ST_ONE;
            end
         end
         default: begin
            state_d    = ST_EMPTY;
            head_dec_d = '0;
            head_err_d = '0;
            tail_dec_d = '0;
            tail_err_d = '0;
         end
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bus.err_clr) begin
         err_cnt_d = '0;
      end else if (push && (|new_err) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         head_dec_q <= '0;
         head_err_q <= '0;
         tail_dec_q <= '0;
         tail_err_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         head_dec_q <= head_dec_d;
         head_err_q <= head_err_d;
         tail_dec_q <= tail_dec_d;
         tail_err_q <= tail_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.in_ready  = (state_q != ST_FULL);
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_dec   = head_dec_q;
   assign bus.out_err   = head_err_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_decoder_proj_stream.sv
// Directed bench for decoder_proj_stream at IN_W=3, OUT_W=7, CHANNELS=2.
module tb_decoder_proj_stream;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   decoder_proj_stream_if #(.IN_W(3), .OUT_W(7), .CHANNELS(2)) bus ();

   decoder_proj_stream #(.IN_W(3), .OUT_W(7), .CHANNELS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // one accepted word with out_ready high: visible one cycle later, then drained
   task automatic xfer_check(input string tag, input logic [5:0] code, input logic [1:0] mode,
                             input logic [13:0] exp_dec, input logic [1:0] exp_err);
      bus.in_code  = code;
      bus.in_mode  = mode;
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      check({tag, " valid"}, 64'(bus.out_valid), 64'(1'b1));
      check({tag, " dec"},   64'(bus.out_dec),   64'(exp_dec));
      check({tag, " err"},   64'(bus.out_err),   64'(exp_err));
      cyc();
   endtask

   initial begin
      logic [6:0] w0, w1;
      tests         = 0;
      fails         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_code   = '0;
      bus.in_mode   = 2'd0;
      bus.out_ready = 1'b1;
      bus.err_clr   = 1'b0;
      #1;
      check("rst out_valid", 64'(bus.out_valid), 64'(1'b0));
      check("rst out_dec",   64'(bus.out_dec),   64'(0));
      check("rst err_cnt",   64'(bus.err_cnt),   64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("post-rst in_ready", 64'(bus.in_ready), 64'(1'b1));

      xfer_check("mode0", {3'd5, 3'd2}, 2'd0, {7'b0100000, 7'b0000100}, 2'b00);
      xfer_check("mode1", {3'd5, 3'd2}, 2'd1, {7'b0111111, 7'b0000111}, 2'b00);
      xfer_check("mode2", {3'd5, 3'd2}, 2'd2, {7'b1011111, 7'b1111011}, 2'b00);
      xfer_check("mode3", {3'd5, 3'd2}, 2'd3, {7'b0100000, 7'b0000100}, 2'b00);
      check("drained out_valid", 64'(bus.out_valid), 64'(1'b0));
      check("drained out_dec",   64'(bus.out_dec),   64'(0));
      check("err_cnt clean",     64'(bus.err_cnt),   64'(0));

      xfer_check("oor m0", {3'd7, 3'd1}, 2'd0, {7'b0000000, 7'b0000010}, 2'b10);
      check("oor m0 err_cnt", 64'(bus.err_cnt), 64'(1));
      xfer_check("oor m2", {3'd7, 3'd1}, 2'd2, {7'b1111111, 7'b1111101}, 2'b10);
      check("oor m2 err_cnt", 64'(bus.err_cnt), 64'(2));
      xfer_check("oor m1", {3'd0, 3'd7}, 2'd1, {7'b0000001, 7'b0000000}, 2'b01);
      check("oor m1 err_cnt", 64'(bus.err_cnt), 64'(3));

      // backpressure: A and B fill the buffer, C waits
      bus.out_ready = 1'b0;
      bus.in_code   = {3'd0, 3'd1};
      bus.in_mode   = 2'd0;
      bus.in_valid  = 1'b1;
      cyc();
      check("bp A in_ready", 64'(bus.in_ready), 64'(1'b1));
      check("bp A head",     64'(bus.out_dec),  64'({7'b0000001, 7'b0000010}));
      bus.in_code = {3'd3, 3'd4};
      bus.in_mode = 2'd1;
      cyc();
      check("bp full in_ready", 64'(bus.in_ready), 64'(1'b0));
      check("bp full head",     64'(bus.out_dec),  64'({7'b0000001, 7'b0000010}));
      bus.in_code = {3'd6, 3'd0};
      bus.in_mode = 2'd2;
      cyc();
      check("bp stall in_ready", 64'(bus.in_ready), 64'(1'b0));
      check("bp stall head",     64'(bus.out_dec),  64'({7'b0000001, 7'b0000010}));
      bus.out_ready = 1'b1;
      cyc();
      check("bp B head",     64'(bus.out_dec),  64'({7'b0001111, 7'b0011111}));
      check("bp B in_ready", 64'(bus.in_ready), 64'(1'b1));
      cyc();
      bus.in_valid = 1'b0;
      check("bp C head",  64'(bus.out_dec),   64'({7'b0111111, 7'b1111110}));
      check("bp C valid", 64'(bus.out_valid), 64'(1'b1));
      cyc();
      check("bp end valid", 64'(bus.out_valid), 64'(1'b0));
      check("bp end dec",   64'(bus.out_dec),   64'(0));

      // streaming: each word appears one cycle after acceptance
      for (int i = 0; i < 16; i++) begin
         bus.in_code  = {3'((i + 3) % 7), 3'(i % 7)};
         bus.in_mode  = 2'd0;
         bus.in_valid = 1'b1;
         w0 = 7'd1 << (i % 7);
         w1 = 7'd1 << ((i + 3) % 7);
         cyc();
         check("stream in_ready", 64'(bus.in_ready), 64'(1'b1));
         check("stream dec",      64'(bus.out_dec),  64'({w1, w0}));
      end
      bus.in_valid = 1'b0;
      cyc();
      check("stream drained", 64'(bus.out_valid), 64'(1'b0));

      // counter saturation and clear priority
      bus.in_code  = {3'd7, 3'd7};
      bus.in_mode  = 2'd0;
      bus.in_valid = 1'b1;
      repeat (260) cyc();
      check("cnt saturate", 64'(bus.err_cnt), 64'(255));
      bus.err_clr = 1'b1;
      cyc();
      check("cnt clear prio", 64'(bus.err_cnt), 64'(0));
      bus.err_clr = 1'b0;
      cyc();
      check("cnt after clear", 64'(bus.err_cnt), 64'(1));
      bus.in_valid = 1'b0;
      cyc();

      // reset with two words buffered
      bus.out_ready = 1'b0;
      bus.in_code   = {3'd7, 3'd2};
      bus.in_valid  = 1'b1;
      cyc();
      cyc();
      check("pre-rst full", 64'(bus.in_ready), 64'(1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 64'(bus.out_valid), 64'(1'b0));
      check("midrst out_dec",   64'(bus.out_dec),   64'(0));
      check("midrst out_err",   64'(bus.out_err),   64'(0));
      check("midrst err_cnt",   64'(bus.err_cnt),   64'(0));
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b1;
      check("release in_ready",  64'(bus.in_ready),  64'(1'b1));
      check("release out_valid", 64'(bus.out_valid), 64'(1'b0));
      xfer_check("post-rst xfer", {3'd1, 3'd6}, 2'd1, {7'b0000011, 7'b1111111}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
